// File: rtl/mbist_march_ctrl_if.sv
// Controller-side bundle: start/status toward the MBIST top plus the fault_mem access port.
interface mbist_march_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  fail;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [2:0]            fail_elem;
   logic [7:0]            fail_count;
   logic                  mem_write_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      input  start, mem_rdata,
      output busy, done, fail, fail_addr, fail_elem, fail_count,
             mem_write_read, mem_address, mem_wdata
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, fail, fail_addr, fail_elem, fail_count,
             mem_write_read, mem_address, mem_wdata
   );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- self-test controller for fault_mem: six elements over 0..CAPACITY, reads compared
// two cycles later, sticky fail with first-failure address/element and saturating count.
module mbist_march_ctrl #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    CAPACITY   = 15,
   parameter logic [DATA_WIDTH-1:0] DATA_BG    = {DATA_WIDTH{1'b0}}
) (
   input logic                clk,
   input logic                rst,
   mbist_march_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, OP, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);

   state_t                state;
   logic [2:0]            elem;
   logic                  drain_last;
   logic                  s0_vld, s1_vld;
   logic [DATA_WIDTH-1:0] s0_exp, s1_exp;
   logic [ADDR_WIDTH-1:0] s0_addr, s1_addr;
   logic [2:0]            s0_elem, s1_elem;
   logic [2:0]            elem_nxt;
   logic                  at_end;
   logic                  two_op;
   logic                  miscmp;

   function automatic logic is_up(input logic [2:0] e);
      return !(e == 3'd3 || e == 3'd4);
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
      return is_up(e) ? {ADDR_WIDTH{1'b0}} : LAST;
   endfunction

   // M1/M3 write the inverted background, M2/M4 expect it back
   function automatic logic [DATA_WIDTH-1:0] wval(input logic [2:0] e);
      return (e == 3'd1 || e == 3'd3) ? ~DATA_BG : DATA_BG;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rval(input logic [2:0] e);
      return (e == 3'd2 || e == 3'd4) ? ~DATA_BG : DATA_BG;
   endfunction

   assign elem_nxt = elem + 3'd1;
   assign two_op   = (elem != 3'd0) && (elem != 3'd5);
   assign at_end   = is_up(elem) ? (bus.mem_address == LAST)
                                 : (bus.mem_address == {ADDR_WIDTH{1'b0}});
   assign miscmp   = s1_vld && (bus.mem_rdata != s1_exp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         elem               <= 3'd0;
         drain_last         <= 1'b0;
         s0_vld             <= 1'b0;
         s1_vld             <= 1'b0;
         s0_exp             <= DATA_BG;
         s1_exp             <= DATA_BG;
         s0_addr            <= '0;
         s1_addr            <= '0;
         s0_elem            <= 3'd0;
         s1_elem            <= 3'd0;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.fail           <= 1'b0;
         bus.fail_addr      <= '0;
         bus.fail_elem      <= 3'd0;
         bus.fail_count     <= 8'd0;
         bus.mem_write_read <= 1'b0;
         bus.mem_address    <= '0;
         bus.mem_wdata      <= DATA_BG;
      end else begin
         s0_vld   <= (state == OP) && !bus.mem_write_read;
         s0_exp   <= rval(elem);
         s0_addr  <= bus.mem_address;
         s0_elem  <= elem;
         s1_vld   <= s0_vld;
         s1_exp   <= s0_exp;
         s1_addr  <= s0_addr;
         s1_elem  <= s0_elem;
         bus.done <= 1'b0;

         if (miscmp) begin
            if (bus.fail_count != 8'hFF) bus.fail_count <= bus.fail_count + 8'd1;
            if (!bus.fail) begin
               bus.fail      <= 1'b1;
               bus.fail_addr <= s1_addr;
               bus.fail_elem <= s1_elem;
            end
         end

         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state              <= SETUP;
                  elem               <= 3'd0;
                  bus.busy           <= 1'b1;
                  bus.mem_write_read <= 1'b0;
                  bus.mem_address    <= first_addr(3'd0);
                  bus.mem_wdata      <= wval(3'd0);
                  bus.fail           <= 1'b0;
                  bus.fail_addr      <= '0;
                  bus.fail_elem      <= 3'd0;
                  bus.fail_count     <= 8'd0;
               end
            end
            SETUP: begin
               state              <= OP;
               bus.mem_write_read <= (elem == 3'd0);
            end
            OP: begin
               if (two_op && !bus.mem_write_read) begin
                  bus.mem_write_read <= 1'b1;
               end else if (at_end) begin
                  bus.mem_write_read <= 1'b0;
                  if (elem == 3'd5) begin
                     state      <= DRAIN;
                     drain_last <= 1'b0;
                  end else begin
                     state           <= SETUP;
                     elem            <= elem_nxt;
                     bus.mem_address <= first_addr(elem_nxt);
                     bus.mem_wdata   <= wval(elem_nxt);
                  end
               end else begin
                  bus.mem_address    <= is_up(elem) ? bus.mem_address + 1'b1
                                                    : bus.mem_address - 1'b1;
                  bus.mem_write_read <= (elem == 3'd0);
               end
            end
            DRAIN: begin
               drain_last <= 1'b1;
               if (drain_last) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: March C- op-list model with faulty-memory evaluation, per-cycle compare.
module tb_mbist_march_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   int   fault_a;

   mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_a ();
   mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_b ();

   mbist_march_ctrl dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   mbist_march_ctrl #(.CAPACITY(3), .DATA_BG(8'hA5)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   // fault kinds: 1 = addr 7 bit 6 stuck-at-0, 2 = writes to 3 also land in 12
   function automatic logic [7:0] fault_read(input int f, input int a, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      if (f == 1 && a == 7) r[6] = 1'b0;
      return r;
   endfunction

   logic [7:0] mem_a [16];
   logic [7:0] wq_a, rd1_a;
   always @(posedge clk) begin
      wq_a <= bus_a.mem_wdata;
      if (bus_a.mem_write_read) begin
         mem_a[bus_a.mem_address] <= wq_a;
         if (fault_a == 2 && bus_a.mem_address == 4'd3) mem_a[12] <= wq_a;
      end
      rd1_a           <= fault_read(fault_a, int'(bus_a.mem_address), mem_a[bus_a.mem_address]);
      bus_a.mem_rdata <= rd1_a;
   end

   logic [7:0] mem_b [16];
   logic [7:0] wq_b, rd1_b;
   always @(posedge clk) begin
      wq_b <= bus_b.mem_wdata;
      if (bus_b.mem_write_read) mem_b[bus_b.mem_address] <= wq_b;
      rd1_b           <= mem_b[bus_b.mem_address];
      bus_b.mem_rdata <= rd1_b;
   end

   typedef struct packed {
      logic       wr;
      logic       chk_addr;
      logic [3:0] addr;
      logic       chk_wd;
      logic [7:0] wd;
      logic       busy;
      logic       done;
      logic       chk_res;
      logic       fail;
      logic [3:0] faddr;
      logic [2:0] felem;
      logic [7:0] fcnt;
   } exp_t;

   exp_t gen_q[$];
   exp_t q_a[$];
   exp_t q_b[$];
   int   tests = 0;
   int   fails = 0;
   int   tick = 0;
   int   t0_a = 0, t0_b = 0;
   int   done_cnt_a = 0, done_cnt_b = 0;
   int   done_cyc_a = 0, done_cyc_b = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // March C- as written: 0=r0 1=r1 2=w0 3=w1, -1 = no second op
   function automatic int op_of(input int el, input int k);
      case (el)
         0:       return (k == 0) ? 2 : -1;
         1, 3:    return (k == 0) ? 0 : 3;
         2, 4:    return (k == 0) ? 1 : 2;
         default: return (k == 0) ? 0 : -1;
      endcase
   endfunction

   // Expected per-cycle outputs from cycle 1 onward, and the result of running the march on the faulty memory
   task automatic build(input int cap, input logic [7:0] bg, input int fault, input bit trail);
      logic [7:0] mm [16];
      exp_t       e;
      int         cnt, op, a;
      bit         got, up, hw;
      logic [3:0] fa;
      logic [2:0] fe;
      logic [7:0] wv, v, rd;
      gen_q.delete();
      cnt = 0; got = 0; fa = 4'd0; fe = 3'd0;
      for (int i = 0; i < 16; i++) mm[i] = 8'h00;
      for (int el = 0; el < 6; el++) begin
         up = (el != 3 && el != 4);
         hw = 0; wv = bg;
         for (int k = 0; k < 2; k++)
            if (op_of(el, k) >= 2) begin hw = 1; wv = (op_of(el, k) == 3) ? ~bg : bg; end
         e = '0; e.busy = 1; e.chk_addr = 1; e.addr = 4'(up ? 0 : cap); e.chk_wd = hw; e.wd = wv;
         gen_q.push_back(e);
         for (int i = 0; i <= cap; i++) begin
            a = up ? i : cap - i;
            for (int k = 0; k < 2; k++) begin
               op = op_of(el, k);
               if (op < 0) continue;
               v = (op % 2 == 1) ? ~bg : bg;
               e = '0; e.busy = 1; e.chk_addr = 1; e.addr = 4'(a); e.chk_wd = hw; e.wd = wv;
               if (op >= 2) begin
                  e.wr = 1; mm[a] = v;
                  if (fault == 2 && a == 3) mm[12] = v;
               end else begin
                  rd = fault_read(fault, a, mm[a]);
                  if (rd !== v) begin
                     if (cnt < 255) cnt++;
                     if (!got) begin got = 1; fa = 4'(a); fe = 3'(el); end
                  end
               end
               gen_q.push_back(e);
            end
         end
      end
      e = '0; e.busy = 1;
      gen_q.push_back(e);
      gen_q.push_back(e);
      e = '0; e.done = 1; e.chk_res = 1; e.fail = got; e.faddr = fa; e.felem = fe; e.fcnt = 8'(cnt);
      gen_q.push_back(e);
      if (trail) begin e = '0; gen_q.push_back(e); end
   endtask

   task automatic check_entry(input string nm, input exp_t e, input int cyc,
                              input logic busy, input logic done, input logic wr,
                              input logic [3:0] addr, input logic [7:0] wd, input logic [7:0] pwd,
                              input logic fail, input logic [3:0] faddr, input logic [2:0] felem,
                              input logic [7:0] fcnt);
      string s;
      s = $sformatf("%s@%0d", nm, cyc);
      chk({s, ".busy"}, busy, e.busy);
      chk({s, ".done"}, done, e.done);
      chk({s, ".write_read"}, wr, e.wr);
      if (e.chk_addr) chk({s, ".address"}, addr, e.addr);
      if (e.chk_wd) chk({s, ".wdata"}, wd, e.wd);
      if (e.wr) chk({s, ".stored_wdata"}, pwd, e.wd);
      if (e.chk_res) begin
         chk({s, ".fail"}, fail, e.fail);
         chk({s, ".fail_addr"}, faddr, e.faddr);
         chk({s, ".fail_elem"}, felem, e.felem);
         chk({s, ".fail_count"}, fcnt, e.fcnt);
      end
   endtask

   // Single compare process, sampling on the falling edge
   initial begin
      exp_t       ea, eb;
      logic [7:0] pwd_a, pwd_b;
      pwd_a = 8'h00; pwd_b = 8'h00;
      forever begin
         @(negedge clk);
         tick++;
         if (bus_a.done === 1'b1) begin done_cnt_a++; done_cyc_a = tick - t0_a; end
         if (bus_b.done === 1'b1) begin done_cnt_b++; done_cyc_b = tick - t0_b; end
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check_entry("a", ea, tick - t0_a, bus_a.busy, bus_a.done, bus_a.mem_write_read,
                        bus_a.mem_address, bus_a.mem_wdata, pwd_a, bus_a.fail, bus_a.fail_addr,
                        bus_a.fail_elem, bus_a.fail_count);
         end
         if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check_entry("b", eb, tick - t0_b, bus_b.busy, bus_b.done, bus_b.mem_write_read,
                        bus_b.mem_address, bus_b.mem_wdata, pwd_b, bus_b.fail, bus_b.fail_addr,
                        bus_b.fail_elem, bus_b.fail_count);
         end
         pwd_a = bus_a.mem_wdata;
         pwd_b = bus_b.mem_wdata;
      end
   end

   task automatic wait_a(input string nm);
      int n;
      n = 0;
      while (q_a.size() != 0 && n < 400) begin @(posedge clk); n++; end
      chk({nm, ".timeout_left"}, q_a.size(), 0);
   endtask

   task automatic run_a(input string nm, input int fault);
      int dc0;
      fault_a = fault;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(negedge clk); #1 build(15, 8'h00, fault, 1'b1);
      q_a = gen_q; t0_a = tick; dc0 = done_cnt_a;
      @(posedge clk); #1 bus_a.start = 1'b0;
      wait_a(nm);
      chk({nm, ".done_cycle"}, done_cyc_a, 169);
      chk({nm, ".done_pulses"}, done_cnt_a - dc0, 1);
   endtask

   initial begin
      int dc0;
      rst_a = 1'b1; rst_b = 1'b1; fault_a = 0;
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("rst.busy", bus_a.busy, 0);
      chk("rst.done", bus_a.done, 0);
      chk("rst.fail", bus_a.fail, 0);
      chk("rst.fail_addr", bus_a.fail_addr, 0);
      chk("rst.fail_elem", bus_a.fail_elem, 0);
      chk("rst.fail_count", bus_a.fail_count, 0);
      chk("rst.write_read", bus_a.mem_write_read, 0);
      chk("rst.address", bus_a.mem_address, 0);
      chk("rst.wdata", bus_a.mem_wdata, 8'h00);
      chk("rst_b.wdata", bus_b.mem_wdata, 8'hA5);
      chk("rst_b.busy", bus_b.busy, 0);

      build(15, 8'h00, 0, 1'b0);
      chk("model.len16", gen_q.size(), 169);

      run_a("clean", 0);
      chk("clean.fail", bus_a.fail, 0);
      chk("clean.fail_count", bus_a.fail_count, 0);

      run_a("stuck", 1);
      chk("stuck.fail", bus_a.fail, 1);
      chk("stuck.fail_addr", bus_a.fail_addr, 7);
      chk("stuck.fail_elem", bus_a.fail_elem, 2);
      chk("stuck.fail_count", bus_a.fail_count, 2);

      run_a("decoder", 2);
      chk("decoder.fail", bus_a.fail, 1);
      chk("decoder.fail_addr", bus_a.fail_addr, 12);
      chk("decoder.fail_elem", bus_a.fail_elem, 1);
      chk("decoder.fail_count", bus_a.fail_count, 2);

      // abort mid-run: reset asserted in cycle 50, released in cycle 52
      fault_a = 0;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      repeat (49) @(posedge clk);
      #1 rst_a = 1'b1;
      #1 chk("abort.busy_async", bus_a.busy, 0);
      chk("abort.fail_cleared", bus_a.fail, 0);
      dc0 = done_cnt_a;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0;
      repeat (200) @(posedge clk);
      chk("abort.no_done", done_cnt_a - dc0, 0);
      chk("abort.idle_busy", bus_a.busy, 0);
      run_a("after_abort", 0);
      chk("after_abort.fail", bus_a.fail, 0);

      // start held through the whole run: restart only from the DONE cycle
      dc0 = done_cnt_a;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(negedge clk); #1 build(15, 8'h00, 0, 1'b0);
      q_a = gen_q; t0_a = tick;
      wait_a("held");
      chk("held.done_cycle", done_cyc_a, 169);
      chk("held.done_pulses", done_cnt_a - dc0, 1);
      #1 build(15, 8'h00, 0, 1'b1);
      q_a = gen_q; t0_a = tick;
      bus_a.start = 1'b0;
      wait_a("held_rerun");
      chk("held_rerun.done_cycle", done_cyc_a, 169);

      // small array with a non-zero background
      build(3, 8'hA5, 0, 1'b0);
      chk("model.len4", gen_q.size(), 49);
      chk("model.m1_wdata", gen_q[5].wd, 8'h5A);
      @(posedge clk); #1 bus_b.start = 1'b1;
      @(negedge clk); #1 build(3, 8'hA5, 0, 1'b1);
      q_b = gen_q; t0_b = tick; dc0 = done_cnt_b;
      @(posedge clk); #1 bus_b.start = 1'b0;
      begin
         int n;
         n = 0;
         while (q_b.size() != 0 && n < 200) begin @(posedge clk); n++; end
         chk("small.timeout_left", q_b.size(), 0);
      end
      chk("small.done_cycle", done_cyc_b, 49);
      chk("small.done_pulses", done_cnt_b - dc0, 1);
      chk("small.fail", bus_b.fail, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
